board_fill_ctrl: RTL
====================

Name: board_fill_ctrl

Overview:
Parametrised successor to the board init/traversal controller. It fills an arbitrary rectangular region of the cell board with one of four fill operations: clear, set, random with programmable density, or a stored pattern. It sits between the edit-mode command decoder and the cell-board write port. All board writes use a valid/ready handshake, so the block tolerates a stalling board memory. Fills can be aborted mid-operation.

Parameters:
MAP_W, 8, board width in cells (2..256)
MAP_H, 8, board height in cells (2..256)
ADDR_W, 8, row/column address width; MAP_W and MAP_H must each be at most 2^ADDR_W
LFSR_SEED, 16'h0339, LFSR reset value; must be nonzero

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  single-cycle request to begin a fill; sampled only in IDLE
op  in  2  fill operation: 0 CLEAR, 1 SET, 2 RANDOM, 3 PATTERN
x0, x1  in  ADDR_W each  rectangle column bounds, inclusive
y0, y1  in  ADDR_W each  rectangle row bounds, inclusive
density  in  8  RANDOM mode: a cell is alive when lfsr[7:0] < density
abort  in  1  terminate the current fill
pat_row, pat_col  out  ADDR_W each  pattern ROM address
pat_data  in  1  pattern ROM bit; valid one cycle after the address is presented
wr_valid  out  1  board write request
wr_ready  in  1  board accepts the write
wr_row, wr_col  out  ADDR_W each  write address
wr_data  out  1  write value
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the last write is accepted
aborted  out  1  one-cycle pulse when a fill is cancelled
err  out  1  one-cycle pulse when a start request is rejected

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, the LFSR holds LFSR_SEED. A reset mid-fill takes effect immediately; no done or aborted pulse follows.
- States: IDLE, FETCH, WRITE, FINISH.
- IDLE, start=1, rectangle legal (x0<=x1<MAP_W and y0<=y1<MAP_H):
  - Latch op, bounds and density.
  - Set cursor to (x0,y0).
  - Go to FETCH if op=PATTERN, otherwise go to WRITE.
- IDLE, start=1, rectangle illegal: err pulses the next cycle, stay IDLE, no writes.
- start while busy: ignored.
- FETCH: drive pat_row/pat_col with the cursor for one cycle, then go to WRITE. In WRITE, register pat_data as wr_data.
- WRITE:
  - wr_valid=1. wr_row, wr_col and wr_data stay stable until wr_ready=1.
  - On the accepting edge (wr_valid and wr_ready both high), advance the cursor in row-major order: col+1; at col=x1, col wraps to x0 and row+1.
  - After the accepted write at (x1,y1), go to FINISH. Otherwise return to FETCH (PATTERN) or stay in WRITE with back-to-back writes, one per cycle when wr_ready is held high.
- wr_data values: CLEAR 0; SET 1; RANDOM (lfsr[7:0] < density); PATTERN the fetched bit.
- density limits: density=0 produces all 0; density=255 produces 1 except when lfsr[7:0]=255.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shift left with feedback into bit 0. It advances only on accepted RANDOM writes, so a stall does not change the value being written.
- FINISH: done=1 for one cycle, then return to IDLE.
- abort: takes priority in FETCH and WRITE. The next cycle is IDLE with wr_valid=0 and aborted=1 for one cycle. A write accepted in the same cycle as abort counts as complete. abort in IDLE is ignored.
- Throughput: N cells take N cycles (non-PATTERN, wr_ready held high) or 2N cycles (PATTERN).

Decomposition:
- Shared defines package holds the fill op encodings (FILL_CLEAR, FILL_SET, FILL_RANDOM, FILL_PATTERN), the FSM state encodings and the LFSR tap constants.
- One sub-module, fill_lfsr: 16-bit LFSR with a seed parameter and advance enable, output lfsr[7:0].

Test Plan:
- MAP 8x8, op=SET, rect (2,1)-(4,2), wr_ready held high -> writes (1,2),(1,3),(1,4),(2,2),(2,3),(2,4) in that order, data 1, six consecutive cycles, then done pulses once.
- op=CLEAR, full board, wr_ready low on every second cycle -> 64 writes with address and data held stable across each stall, all data 0, done after the 64th accept.
- op=RANDOM, density=0 then density=255, 4x4 region -> all writes 0 for density=0; for density=255, every write compared against a reference LFSR model, sequence starting from seed 0x0339.
- op=PATTERN with a ROM model of 1-cycle latency, 3x3 region -> each wr_data equals ROM[row][col], one write every 2 cycles.
- Rect x0=5, x1=3 -> err pulses, busy stays 0, no wr_valid. Separately, start with x1=MAP_W -> err pulses.
- abort asserted after the 10th accept of a 64-cell fill -> wr_valid low the next cycle, aborted pulses, no done; a following start runs normally.

Source files
------------

// File: rtl/board_fill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : board_fill_ctrl_pkg
// Brief  : Shared fill-op, FSM-state and LFSR tap definitions.
// Rev    : 1.0  initial release
// ============================================================================
package board_fill_ctrl_pkg;

    localparam logic [1:0] FILL_CLEAR   = 2'd0;
    localparam logic [1:0] FILL_SET     = 2'd1;
    localparam logic [1:0] FILL_RANDOM  = 2'd2;
    localparam logic [1:0] FILL_PATTERN = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_fb(input logic [15:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/board_fill_ctrl_lfsr.sv
`default_nettype none
// ============================================================================
// Module : fill_lfsr
// Brief  : 16-bit Fibonacci LFSR, shifts left on advance, exposes low byte.
// Rev    : 1.0  initial release
// ============================================================================
module fill_lfsr
    import board_fill_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = 16'h0339
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    output logic [7:0] lfsr_lo
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb(lfsr_q)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_lo = lfsr_q[7:0];

endmodule
`default_nettype wire

// File: rtl/board_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module : board_fill_ctrl
// Brief  : Rectangular board fill (clear/set/random/pattern) over a
//          valid/ready write port, abortable mid-fill.
// Rev    : 1.0  initial release
// ============================================================================
module board_fill_ctrl
    import board_fill_ctrl_pkg::*;
#(
    parameter int unsigned MAP_W     = 8,
    parameter int unsigned MAP_H     = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter logic [15:0] LFSR_SEED = 16'h0339
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] x0,
    input  logic [ADDR_W-1:0] x1,
    input  logic [ADDR_W-1:0] y0,
    input  logic [ADDR_W-1:0] y1,
    input  logic [7:0]        density,
    input  logic              abort,
    output logic [ADDR_W-1:0] pat_row,
    output logic [ADDR_W-1:0] pat_col,
    input  logic              pat_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_row,
    output logic [ADDR_W-1:0] wr_col,
    output logic              wr_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err
);

    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
    logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
    logic [7:0]        dens_q, dens_d;
    logic              first_q, first_d;
    logic              pat_q, pat_d;
    logic              err_q, err_d;
    logic              aborted_q, aborted_d;

    logic              accept;
    logic              last_cell;
    logic              legal;
    logic              lfsr_adv;
    logic [7:0]        lfsr_lo;

    assign accept    = (state_q == ST_WRITE) && wr_ready;
    assign last_cell = (row_q == y1_q) && (col_q == x1_q);
    assign legal     = (x0 <= x1) && (32'(x1) < MAP_W) &&
                       (y0 <= y1) && (32'(y1) < MAP_H);
    assign lfsr_adv  = accept && (op_q == FILL_RANDOM);

    fill_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .adv     (lfsr_adv),
        .lfsr_lo (lfsr_lo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            op_q      <= FILL_CLEAR;
            x0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            dens_q    <= '0;
            first_q   <= 1'b0;
            pat_q     <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            row_q     <= row_d;
            col_q     <= col_d;
            dens_q    <= dens_d;
            first_q   <= first_d;
            pat_q     <= pat_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && legal) begin
                    state_d = (op == FILL_PATTERN) ? ST_FETCH : ST_WRITE;
                end
            end
            ST_FETCH: begin
                state_d = abort ? ST_IDLE : ST_WRITE;
            end
            ST_WRITE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    if (last_cell) begin
                        state_d = ST_FINISH;
                    end else if (op_q == FILL_PATTERN) begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d      = op_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        row_d     = row_q;
        col_d     = col_q;
        dens_d    = dens_q;
        first_d   = first_q;
        pat_d     = pat_q;
        err_d     = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (legal) begin
                        op_d    = op;
                        x0_d    = x0;
                        x1_d    = x1;
                        y1_d    = y1;
                        dens_d  = density;
                        row_d   = y0;
                        col_d   = x0;
                        first_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                first_d   = 1'b1;
                aborted_d = abort;
            end
            ST_WRITE: begin
                aborted_d = abort;
                // ROM bit is only valid in the first WRITE cycle; hold it across stalls
                if (first_q) begin
                    first_d = 1'b0;
                    pat_d   = pat_data;
                end
                if (accept) begin
                    if (col_q == x1_q) begin
                        col_d = x0_q;
                        row_d = row_q + ADDR_W'(1);
                    end else begin
                        col_d = col_q + ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_valid = (state_q == ST_WRITE);
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_FINISH);
        aborted  = aborted_q;
        err      = err_q;
        wr_row   = row_q;
        wr_col   = col_q;
        pat_row  = (state_q == ST_FETCH) ? row_q : '0;
        pat_col  = (state_q == ST_FETCH) ? col_q : '0;
        wr_data  = 1'b0;
        if (state_q == ST_WRITE) begin
            case (op_q)
                FILL_SET:     wr_data = 1'b1;
                FILL_RANDOM:  wr_data = (lfsr_lo < dens_q);
                FILL_PATTERN: wr_data = first_q ? pat_data : pat_q;
                default:      wr_data = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire
